fp16_mul_byte_driver: RTL and testbench

- Host-side initiator for the byte-serial FP16 multiplier tile, mapped onto its ui_in/uio_in/uo_out pins.
- Accepts a pair of 16-bit FP16 operands on a valid/ready port and sends a start byte, then the operand bytes low byte first.
- Waits the tile's fixed processing latency, captures the two result bytes low byte first, and presents the 16-bit result on a valid/ready port.
- Used in the FPGA/SoC harness and as the reusable bench driver for the tile.

---
 rtl/fp16_mul_byte_driver.sv | 112 +++++++++++
 tb/tb_fp16_mul_byte_driver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_mul_byte_driver.sv
// Host-side initiator for the byte-serial FP16 multiplier tile: start byte, operand bytes, then
// captures the two result bytes at a fixed offset and presents them on a valid/ready port.
module fp16_mul_byte_driver #(
  parameter logic [7:0] START_CODE = 8'h01,
  parameter int         CAP_LO_OFS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
  output logic [7:0]  tx_ui,
  output logic [7:0]  tx_uio,
  input  logic [7:0]  rx_uo
);

  if (START_CODE == 8'h00) begin : g_bad_start
    $error("fp16_mul_byte_driver: START_CODE must be nonzero");
  end
  // The SEND phase owns counter values 0..2, and the counter must reach CAP_LO_OFS+1 in 4 bits.
  if (CAP_LO_OFS < 4 || CAP_LO_OFS > 14) begin : g_bad_ofs
    $error("fp16_mul_byte_driver: CAP_LO_OFS out of range 4..14");
  end

  localparam logic [3:0] WAIT_LAST = 4'(CAP_LO_OFS - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, CAP_LO, CAP_HI} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [7:0]  lo_byte;
  logic        accept;

  assign op_ready = (state == IDLE) && (!res_valid || res_ready);
  assign accept   = op_valid && op_ready;

  // The counter value always equals the c-index of the current cycle within a transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      lo_byte   <= 8'h00;
      tx_ui     <= 8'h00;
      tx_uio    <= 8'h00;
      res_valid <= 1'b0;
      res_data  <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= op_a;
            b_q    <= op_b;
            cnt    <= 4'd0;
            tx_ui  <= START_CODE;
            tx_uio <= 8'h00;
            busy   <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          cnt <= cnt + 4'd1;
          case (cnt)
            4'd0: begin
              tx_ui  <= a_q[7:0];
              tx_uio <= b_q[7:0];
            end
            4'd1: begin
              tx_ui  <= a_q[15:8];
              tx_uio <= b_q[15:8];
            end
            default: begin
              tx_ui  <= 8'h00;
              tx_uio <= 8'h00;
              state  <= WAIT;
            end
          endcase
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == WAIT_LAST) state <= CAP_LO;
        end
        CAP_LO: begin
          cnt     <= cnt + 4'd1;
          lo_byte <= rx_uo;
          state   <= CAP_HI;
        end
        CAP_HI: begin
          res_data  <= {rx_uo, lo_byte};
          res_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_mul_byte_driver.sv
// Directed bench for fp16_mul_byte_driver with a behavioural model of the byte-serial tile.
module tb_fp16_mul_byte_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] op_a = 16'h0000;
  logic [15:0] op_b = 16'h0000;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic        busy;
  logic [7:0]  tx_ui;
  logic [7:0]  tx_uio;
  logic [7:0]  rx_uo;

  int n_checks = 0;
  int n_pass = 0;

  fp16_mul_byte_driver dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .tx_ui(tx_ui), .tx_uio(tx_uio), .rx_uo(rx_uo)
  );

  always #5 clk = ~clk;

  // Tile model: normal-number FP16 multiply, truncating; result bytes on uo in c10 and c11.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    logic [9:0]  m;
    int          e;
    p = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[20:11];
      e = e + 1;
    end else begin
      m = p[19:10];
    end
    return {a[15] ^ b[15], 5'(e), m};
  endfunction

  int          tcnt;
  logic [7:0]  ta_lo, tb_lo;
  logic [15:0] tprod;

  always @(posedge clk) begin
    if (!rst_n) begin
      tcnt  <= 0;
      ta_lo <= 8'h00;
      tb_lo <= 8'h00;
      tprod <= 16'h0000;
    end else if (tcnt == 0) begin
      if (tx_ui != 8'h00) tcnt <= 1;
    end else begin
      tcnt <= (tcnt == 11) ? 0 : tcnt + 1;
      if (tcnt == 1) begin
        ta_lo <= tx_ui;
        tb_lo <= tx_uio;
      end
      if (tcnt == 2) tprod <= fmul({tx_ui, ta_lo}, {tx_uio, tb_lo});
    end
  end

  assign rx_uo = (tcnt == 10) ? tprod[7:0] : (tcnt == 11) ? tprod[15:8] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [7:0] tr_ui [0:15];
  logic [7:0] tr_uio [0:15];

  // Presents an operand pair at a falling edge and returns just after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    logic ok;
    @(negedge clk);
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (op_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  // Index k = number of the cycle c_k (relative to the accept edge) in which res_valid is seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output int lat);
    issue(a, b);
    lat = -1;
    res = 16'hxxxx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 16) begin
        tr_ui[k]  = tx_ui;
        tr_uio[k] = tx_uio;
      end
      if (res_valid) begin
        lat = k;
        res = res_data;
        break;
      end
    end
    if (lat < 0) check("result_timeout", 32'd0, 32'd1);
  endtask

  logic        mon_en = 1'b0;
  int          mon_cyc = 0;
  int          n_starts = 0;
  int          n_nz = 0;
  int          starts [0:7];

  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_ui != 8'h00) n_nz++;
      if (tx_ui == 8'h01 && n_starts < 8) begin
        starts[n_starts] = mon_cyc;
        n_starts++;
      end
      mon_cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    int          lat;
    logic [7:0]  exp_ui  [0:3];
    logic [7:0]  exp_uio [0:3];
    logic [15:0] ba [0:3];
    logic [15:0] bb [0:3];
    logic [15:0] bexp [0:3];
    logic [15:0] bgot [0:3];
    logic        seen;

    exp_ui  = '{8'h01, 8'h34, 8'h12, 8'h00};
    exp_uio = '{8'h00, 8'hCD, 8'hAB, 8'h00};
    ba   = '{16'h4200, 16'h3800, 16'h3E00, 16'h3C00};
    bb   = '{16'h4000, 16'h4400, 16'h3E00, 16'hC000};
    bexp = '{16'h4600, 16'h4000, 16'h4080, 16'hC000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_ui", 32'(tx_ui), 32'h0);
    check("rst_tx_uio", 32'(tx_uio), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", 32'(res_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_op_ready", 32'(op_ready), 32'h1);

    // Pin trace
    run_op(16'h1234, 16'hABCD, res, lat);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("trace_ui_c%0d", k), 32'(tr_ui[k]), 32'(exp_ui[k]));
      check($sformatf("trace_uio_c%0d", k), 32'(tr_uio[k]), 32'(exp_uio[k]));
    end
    for (int k = 4; k < 12; k++) begin
      check($sformatf("trace_ui_c%0d", k), 32'(tr_ui[k]), 32'h0);
      check($sformatf("trace_uio_c%0d", k), 32'(tr_uio[k]), 32'h0);
    end
    check("trace_latency", 32'(lat), 32'd12);

    // Products through the tile
    run_op(16'h4000, 16'h4000, res, lat);
    check("mul_2x2", 32'(res), 32'h4400);
    check("mul_2x2_latency", 32'(lat), 32'd12);
    run_op(16'h3C00, 16'h3C00, res, lat);
    check("mul_1x1", 32'(res), 32'h3C00);
    run_op(16'hC000, 16'h4000, res, lat);
    check("mul_neg2x2", 32'(res), 32'hC400);

    // Back-pressure: pending result blocks new operands
    @(negedge clk);
    res_ready = 1'b0;
    run_op(16'h4000, 16'h4000, res, lat);
    check("bp_first", 32'(res), 32'h4400);
    op_a = 16'h3C00;
    op_b = 16'hC000;
    op_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(res_valid), 32'h1);
      check("bp_hold_data", 32'(res_data), 32'h4400);
      check("bp_op_ready", 32'(op_ready), 32'h0);
      check("bp_busy", 32'(busy), 32'h0);
    end
    res_ready = 1'b1;
    #1 check("bp_ready_comb", 32'(op_ready), 32'h1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    check("bp_consumed", 32'(res_valid), 32'h0);
    check("bp_new_busy", 32'(busy), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp_second_seen", 32'(seen), 32'h1);
    check("bp_second", 32'(res_data), 32'hC000);

    // Back-to-back issue with res_ready held high
    @(negedge clk);
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(ba[i], bb[i]);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          bgot[i] = 16'hxxxx;
          for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (res_valid) begin
              bgot[i] = res_data;
              break;
            end
          end
          @(posedge clk);
        end
      end
    join
    @(negedge clk);
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("b2b_res%0d", i), 32'(bgot[i]), 32'(bexp[i]));
    check("b2b_starts", 32'(n_starts), 32'd4);
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b_gap%0d", i), 32'(starts[i] - starts[i-1]), 32'd13);
    check("b2b_nonzero_ui", 32'(n_nz), 32'd8);

    // Reset mid-transaction
    issue(16'h4000, 16'h4000);
    for (int k = 0; k < 6; k++) @(negedge clk);
    check("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tx_ui", 32'(tx_ui), 32'h0);
    check("mid_rst_res_valid", 32'(res_valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (res_valid || tx_ui != 8'h00) seen = 1'b1;
    end
    check("mid_no_result", 32'(seen), 32'h0);
    run_op(16'h3C00, 16'h3C00, res, lat);
    check("post_rst_1x1", 32'(res), 32'h3C00);
    check("post_rst_latency", 32'(lat), 32'd12);
    run_op(16'hC000, 16'h4000, res, lat);
    check("post_rst_neg", 32'(res), 32'hC400);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
